// File: rtl/alu_dispatch_unit.sv
// -----------------------------------------------------------------------------
// alu_dispatch_unit
//
// Execute-stage controller placed directly upstream of an 8-bit combinational
// ALU. It accepts one 19-bit instruction at a time over a valid/ready
// handshake and reads its operands from an internal 8x8 register file. It
// drives the ALU SEL/A/B inputs, captures the ALU result and writes it back to
// the register file. The unary ops (inc/dec/shl/shr/not) are computed locally
// from the registered A operand, so the ALU only ever sees binary work.
//
// Instruction word:
//   [18]    imm flag (B operand = imm8 when set, reg[rt] otherwise)
//   [17:14] op
//   [13:11] rd
//   [10:8]  rs
//   [7:0]   imm8, or {5'bx, rt} when imm=0
//
// Ports:
//   CLK       in   1   clock, all state changes on posedge
//   RST       in   1   synchronous active-high reset
//   IN_VALID  in   1   INSTR valid
//   IN_READY  out  1   block can accept an instruction (IDLE only)
//   INSTR     in   19  instruction word
//   ALU_SEL   out  5   ALU operation select
//   ALU_A     out  8   ALU operand A
//   ALU_B     out  8   ALU operand B
//   ALU_C     in   8   ALU result
//   WB_VALID  out  1   one-cycle writeback strobe
//   WB_ADDR   out  3   destination register of the writeback
//   WB_DATA   out  8   value written
//   DIV0_ERR  out  1   pulses with WB_VALID on a divide by zero
//   RD_ADDR   in   3   debug read address
//   RD_DATA   out  8   combinational regfile[RD_ADDR]
//   ZERO      out  1   registered (WB_DATA == 0) flag, present only when
//                      ALU_ZFLAG_EN is defined
//
// Build option:
//   ALU_ZFLAG_EN  when defined, adds the ZERO output and its flag register.
//
// Parameters:
//   REG_RESET    value loaded into every register-file entry on reset
//   DIV0_RESULT  value written back for a divide whose B operand is zero
//
// Timing: accept at edge N, operands registered at edge N+1, result written
// at edge N+2 so WB_* is visible in the cycle following EXEC. One
// instruction per three cycles.
// -----------------------------------------------------------------------------
module alu_dispatch_unit #(
  parameter logic [7:0] REG_RESET   = 8'h00,
  parameter logic [7:0] DIV0_RESULT = 8'hFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [18:0] INSTR,
  output logic [4:0]  ALU_SEL,
  output logic [7:0]  ALU_A,
  output logic [7:0]  ALU_B,
  input  logic [7:0]  ALU_C,
  output logic        WB_VALID,
  output logic [2:0]  WB_ADDR,
  output logic [7:0]  WB_DATA,
  output logic        DIV0_ERR,
  input  logic [2:0]  RD_ADDR,
  output logic [7:0]  RD_DATA
`ifdef ALU_ZFLAG_EN
  ,
  output logic        ZERO
`endif
);

  // State table
  //   state  | meaning
  //   S_IDLE | ready for a new instruction
  //   S_READ | operands read from regfile into ALU_A/ALU_B/ALU_SEL
  //   S_EXEC | ALU (or local unit) result valid, written at end of cycle
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_INC = 4'b0100;
  localparam logic [3:0] OP_DEC = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1011;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        wb_fire;

  logic [18:0] instr_q;
  logic [7:0]  regs [8];

  logic        ins_imm;
  logic [3:0]  ins_op;
  logic [2:0]  ins_rd;
  logic [2:0]  ins_rs;
  logic [2:0]  ins_rt;
  logic [7:0]  ins_imm8;

  logic        op_local;
  logic        op_div0;
  logic [7:0]  local_res;
  logic [7:0]  exec_res;

  function automatic logic is_local_op(input logic [3:0] op);
    return (op == OP_INC) || (op == OP_DEC) || (op == OP_SHL) ||
           (op == OP_SHR) || (op == OP_NOT);
  endfunction

  // ---------------------------------------------------------------------------
  // Instruction field decode (from the latched word)
  // ---------------------------------------------------------------------------
  assign ins_imm  = instr_q[18];
  assign ins_op   = instr_q[17:14];
  assign ins_rd   = instr_q[13:11];
  assign ins_rs   = instr_q[10:8];
  assign ins_rt   = instr_q[2:0];
  assign ins_imm8 = instr_q[7:0];

  assign op_local = is_local_op(ins_op);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    IN_READY  = 1'b0;
    accept    = 1'b0;
    wb_fire   = 1'b0;
    case (state)
      S_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          accept    = 1'b1;
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        wb_fire   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Instruction latch. Upstream holds INSTR until accepted, so capturing it
  // once on accept is enough; later IN_VALID pulses outside IDLE are ignored.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_q <= '0;
    end else if (accept) begin
      instr_q <= INSTR;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand registers driving the ALU. Local ops present SEL=0 so the ALU
  // sees a harmless add whose result is never used.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      ALU_SEL <= '0;
      ALU_A   <= '0;
      ALU_B   <= '0;
    end else if (state == S_READ) begin
      ALU_SEL <= op_local ? 5'b00000 : {1'b0, ins_op};
      ALU_A   <= regs[ins_rs];
      ALU_B   <= ins_imm ? ins_imm8 : regs[ins_rt];
    end
  end

  // ---------------------------------------------------------------------------
  // Execute: local unary unit and result selection
  // ---------------------------------------------------------------------------
  always_comb begin
    local_res = ALU_A;
    case (ins_op)
      OP_INC:  local_res = ALU_A + 8'd1;
      OP_DEC:  local_res = ALU_A - 8'd1;
      OP_SHL:  local_res = {ALU_A[6:0], 1'b0};
      OP_SHR:  local_res = {1'b0, ALU_A[7:1]};
      OP_NOT:  local_res = ~ALU_A;
      default: local_res = ALU_A;
    endcase
  end

  // Divide by zero substitutes a fixed value; whatever the ALU returns is
  // discarded in that case.
  assign op_div0 = (ins_op == OP_DIV) && (ALU_B == 8'h00);

  always_comb begin
    exec_res = ALU_C;
    if (op_local) begin
      exec_res = local_res;
    end else if (op_div0) begin
      exec_res = DIV0_RESULT;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file. The write lands at the edge ending EXEC, after the READ of
  // the same instruction, so rd==rs needs no special handling.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= REG_RESET;
      end
    end else if (wb_fire) begin
      regs[ins_rd] <= exec_res;
    end
  end

  assign RD_DATA = regs[RD_ADDR];

  // ---------------------------------------------------------------------------
  // Writeback report. WB_ADDR/WB_DATA hold their last value between strobes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      WB_VALID <= 1'b0;
      WB_ADDR  <= '0;
      WB_DATA  <= '0;
      DIV0_ERR <= 1'b0;
    end else begin
      WB_VALID <= wb_fire;
      DIV0_ERR <= wb_fire && op_div0;
      if (wb_fire) begin
        WB_ADDR <= ins_rd;
        WB_DATA <= exec_res;
      end
    end
  end

`ifdef ALU_ZFLAG_EN
  // Zero flag tracks the most recent writeback and holds in between.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ZERO <= 1'b0;
    end else if (wb_fire) begin
      ZERO <= (exec_res == 8'h00);
    end
  end
`endif

endmodule
